key_schedule_sequencer: RTL and testbench
=========================================

# key_schedule_sequencer

Sequential AES key-schedule controller. It accepts a cipher key through a valid/ready handshake and expands it word-serially, producing one 32-bit schedule word per clock through a single shared SubWord/Rcon datapath. Each word goes into an internal round-key store. The store serves the encoder/decoder round pipelines through a registered random-access read port. This is the low-area sequenced counterpart of the combinational all-rounds key expansion, and the cipher datapath waits on `scheduleValid` before using round keys.

## Interface
- `KEY_SIZE`, default 128: key width in bits; legal values are 128, 192 and 256.
- `NUM_ROUNDS`, default 10: cipher rounds; must be 10, 12 or 14, matching `KEY_SIZE`.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `keyValid`  in  1  a new key is presented on `keyIn`.
- `keyIn`  in  KEY_SIZE  cipher key; bits [KEY_SIZE-1:KEY_SIZE-8] hold key byte 0 (FIPS-197 order).
- `keyReady`  out  1  block accepts a key this cycle.
- `busy`  out  1  expansion in progress.
- `scheduleValid`  out  1  all NUM_ROUNDS+1 round keys are stored and stable.
- `rdIndex`  in  4  round-key index, 0..NUM_ROUNDS.
- `rdKey`  out  128  round key `rdIndex`, registered; bits [127:96] hold word 4r.
- `rdValid`  out  1  qualifies `rdKey` (see Configuration).

## Operation
- Derived constants:
  - Nk = KEY_SIZE/32.
  - W = 4·(NUM_ROUNDS+1), giving 44, 52 or 60 words.
  - N = W−Nk, giving 40, 46 or 52 expansion cycles.
- Word store: W×32 flops, all cleared on reset.
- State machine: IDLE, EXPAND, DONE.
- IDLE:
  - `keyReady`=1.
  - On `keyValid`: load w[0..Nk−1] from `keyIn`, set i=Nk, set rcon=0x01, go to EXPAND.
- EXPAND:
  - `keyReady`=0 and `busy`=1; `keyValid` is ignored.
  - Each cycle, write w[i] = w[i−Nk] ^ temp, where temp is:
    - if i mod Nk = 0: SubWord(RotWord(w[i−1])) ^ {rcon,24'h0}; then rcon ← xtime(rcon), with 0x80 becoming 0x1b.
    - else if Nk=8 and i mod 8 = 4: SubWord(w[i−1]).
    - otherwise: w[i−1].
  - i is a 6-bit counter. When i = W−1 has been written, go to DONE.
- DONE:
  - `scheduleValid`=1 and `keyReady`=1.
  - On `keyValid` (rekey): behave as in IDLE and go to EXPAND. `scheduleValid` drops on the same edge.
- SubWord: four S-box instances (the shared Sbox.mem table), used only by the expansion datapath.
- Read port:
  - Every cycle, rdKey ← {w[4r], w[4r+1], w[4r+2], w[4r+3]} with r = `rdIndex`.
  - If `rdIndex` > NUM_ROUNDS, rdKey ← 0.
  - The read port is independent of the state machine and reads the store as it currently is.
- Parameter mismatch (KEY_SIZE/NUM_ROUNDS pairing) is not checked; the instantiating encoder/decoder guarantees it.

## Timing
- Reset values:
  - state IDLE, so `keyReady`=1.
  - `busy`=0, `scheduleValid`=0, `rdKey`=0, `rdValid`=0.
  - rcon=0x01, i=0, store all zero.
- Handshake: a transfer occurs on an edge where `keyValid` and `keyReady` are both 1 (edge E0).
- Word Nk is written at edge E1, and the last word at edge E_N.
- `busy` is high from after E0 through E_N.
- `scheduleValid` and `keyReady` are high from after E_N; latency is N cycles from the accept edge.
- Read latency: 1 cycle. `rdKey` and `rdValid` reflect the `rdIndex` sampled at the previous edge.
- Reset asserted mid-EXPAND wins over all other activity: next state IDLE, store cleared, `scheduleValid`=0. The aborted key is lost.
- A key presented while `keyReady`=0 is not consumed; the source must hold `keyValid` and `keyIn` until accepted.

## Configuration
- Macro: `KEYSCHED_EARLY_READ_EN`.
- Defined: `rdValid` ← 1 when round `rdIndex` is complete, i.e. word 4r+3 has been written in the current schedule. This lets the encoder start round 0 and later rounds while expansion continues. A rekey invalidates rounds not yet rewritten.
- Undefined: `rdValid` ← `scheduleValid` & (`rdIndex` ≤ NUM_ROUNDS). No per-round tracking logic is built.

## Test plan
- 128-bit key, after reset:
  - Stimulus: key 2b7e1516 28aed2a6 abf71588 09cf4f3c accepted at E0.
  - Required: `scheduleValid` rises after 40 cycles; rdIndex=10 gives d014f9a8 c9ee2589 e13f0cc8 b6630ca6; rdIndex=0 returns the key.
- 192-bit key:
  - Stimulus: 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b.
  - Required: valid after 46 cycles; rdIndex=12 gives word w[51] = 01002202 in bits [31:0].
- 256-bit key:
  - Stimulus: 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - Required: valid after 52 cycles; rdIndex=14 gives w[59] = 706c631e in bits [31:0].
- Reset mid-operation:
  - Stimulus: assert `reset` 20 cycles into a 128-bit expansion.
  - Required: next cycle `busy`=0, `keyReady`=1, and rdKey=0 for every index.
- Rekey and ignored key:
  - Stimulus: in DONE, present the FIPS-197 key 000102…0f with `keyValid` held.
  - Required: `scheduleValid` drops; `keyValid` toggling during EXPAND is ignored; round 10 = 13111d7f e3944a17 f307a78b 4d2b30c5.
- Out-of-range read and early read:
  - Stimulus: rdIndex=15.
  - Required: rdKey=0 and `rdValid`=0.
  - With `KEYSCHED_EARLY_READ_EN`, rdIndex=1: `rdValid` rises 4 cycles after E0 (w[7] written at E4).

Source files
------------

// File: rtl/key_schedule_sequencer_if.sv
// Key-schedule bus: key load handshake, status flags and the round-key read port.
// Shared by the key_schedule_sequencer (slave side) and its user (master side).
interface key_schedule_sequencer_if #(
    parameter int KEY_SIZE = 128
);
    logic                keyValid;
    logic [KEY_SIZE-1:0] keyIn;
    logic                keyReady;
    logic                busy;
    logic                scheduleValid;
    logic [3:0]          rdIndex;
    logic [127:0]        rdKey;
    logic                rdValid;

    modport master (
        output keyValid, keyIn, rdIndex,
        input  keyReady, busy, scheduleValid, rdKey, rdValid
    );

    modport slave (
        input  keyValid, keyIn, rdIndex,
        output keyReady, busy, scheduleValid, rdKey, rdValid
    );
endinterface

// File: rtl/key_schedule_sequencer.sv
// Word-serial AES key expansion (128/192/256-bit keys) into an internal
// round-key store with a registered random-access read port.
// One schedule word is produced per clock through a single shared
// SubWord/Rcon datapath.
// Optional feature macro: KEYSCHED_EARLY_READ_EN -- per-round completion
// tracking so rounds can be read while expansion is still running.
module key_schedule_sequencer #(
    parameter int KEY_SIZE   = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    key_schedule_sequencer_if.slave   bus
);
    localparam int         NK  = KEY_SIZE / 32;
    localparam int         W   = 4 * (NUM_ROUNDS + 1);
    localparam logic [5:0] NK6 = 6'(NK);
    localparam logic [5:0] W1  = 6'(W - 1);
    localparam logic [3:0] MAX_ROUND = 4'(NUM_ROUNDS);

    // AES S-box, byte 0x00 at the most significant end.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] f_sbox(input logic [7:0] a);
        return SBOX_TABLE[{~a, 3'b000} +: 8];
    endfunction

    // GF(2^8) doubling; 0x80 wraps to 0x1b.
    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_i;
    logic [2:0]  r_phase;       // i mod Nk, kept as its own counter
    logic [7:0]  r_rcon;
    logic        r_key_ready;
    logic        r_busy;
    logic        r_sched_valid;
    logic [31:0] r_w [0:W-1];
    logic [127:0] r_rd_key;
    logic        r_rd_valid;

    logic        w_accept;
    logic [31:0] w_prev;
    logic [31:0] w_back;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub_out;
    logic [31:0] w_temp;
    logic [31:0] w_next_word;
    logic [5:0]  w_base;
    logic        w_out_of_range;
    logic [31:0] w_rd_word [0:3];

    assign w_accept = bus.keyValid && r_key_ready;

    // Shared expansion datapath: RotWord only on the Rcon step, one SubWord for all cases.
    always_comb begin
        w_prev    = r_w[r_i - 6'd1];
        w_back    = r_w[r_i - NK6];
        w_sub_in  = (r_phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        w_sub_out = {f_sbox(w_sub_in[31:24]), f_sbox(w_sub_in[23:16]),
                     f_sbox(w_sub_in[15:8]),  f_sbox(w_sub_in[7:0])};
        if (r_phase == 3'd0)
            w_temp = w_sub_out ^ {r_rcon, 24'h0};
        else if (NK == 8 && r_phase == 3'd4)
            w_temp = w_sub_out;
        else
            w_temp = w_prev;
        w_next_word = w_back ^ w_temp;
    end

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_i           <= 6'd0;
            r_phase       <= 3'd0;
            r_rcon        <= 8'h01;
            r_key_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_sched_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.keyValid) begin
                        r_state       <= S_EXPAND;
                        r_i           <= NK6;
                        r_phase       <= 3'd0;
                        r_rcon        <= 8'h01;
                        r_key_ready   <= 1'b0;
                        r_busy        <= 1'b1;
                        r_sched_valid <= 1'b0;
                    end
                end
                S_EXPAND: begin
                    r_phase <= (r_phase == 3'(NK - 1)) ? 3'd0 : r_phase + 3'd1;
                    if (r_phase == 3'd0)
                        r_rcon <= f_xtime(r_rcon);
                    if (r_i == W1) begin
                        r_state       <= S_DONE;
                        r_key_ready   <= 1'b1;
                        r_busy        <= 1'b0;
                        r_sched_valid <= 1'b1;
                    end else begin
                        r_i <= r_i + 6'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Word store: cleared on reset, key words loaded on accept, one expanded word per cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < W; k++)
                r_w[k] <= 32'h0;
        end else if (w_accept) begin
            for (int k = 0; k < NK; k++)
                r_w[k] <= bus.keyIn[KEY_SIZE-1-32*k -: 32];
        end else if (r_busy) begin
            r_w[r_i] <= w_next_word;
        end
    end

    assign w_base         = {bus.rdIndex, 2'b00};
    assign w_out_of_range = (bus.rdIndex > MAX_ROUND);

    // Read-port word select; with early read the word being written this cycle is forwarded.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_rd_word[k] = r_w[w_base + 6'(k)];
`ifdef KEYSCHED_EARLY_READ_EN
            if (r_busy && r_i == w_base + 6'(k))
                w_rd_word[k] = w_next_word;
`endif
        end
    end

`ifdef KEYSCHED_EARLY_READ_EN
    logic [NUM_ROUNDS:0] r_round_done;

    // Per-round completion: a round is complete once its last word (4r+3) is written.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_round_done <= '0;
        end else if (w_accept) begin
            for (int r = 0; r <= NUM_ROUNDS; r++)
                r_round_done[r] <= (4 * r + 3 < NK);
        end else if (r_busy) begin
            for (int r = 0; r <= NUM_ROUNDS; r++)
                if (r_i == 6'(4 * r + 3))
                    r_round_done[r] <= 1'b1;
        end
    end

    // Registered read port with per-round qualification.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_key   <= 128'h0;
            r_rd_valid <= 1'b0;
        end else if (w_out_of_range) begin
            r_rd_key   <= 128'h0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_key   <= {w_rd_word[0], w_rd_word[1], w_rd_word[2], w_rd_word[3]};
            r_rd_valid <= r_round_done[bus.rdIndex] ||
                          (r_busy && r_i == w_base + 6'd3);
        end
    end
`else
    // Registered read port qualified by schedule completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_key   <= 128'h0;
            r_rd_valid <= 1'b0;
        end else if (w_out_of_range) begin
            r_rd_key   <= 128'h0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_key   <= {w_rd_word[0], w_rd_word[1], w_rd_word[2], w_rd_word[3]};
            r_rd_valid <= r_sched_valid;
        end
    end
`endif

    assign bus.keyReady      = r_key_ready;
    assign bus.busy          = r_busy;
    assign bus.scheduleValid = r_sched_valid;
    assign bus.rdKey         = r_rd_key;
    assign bus.rdValid       = r_rd_valid;
endmodule

// File: tb/tb_key_schedule_sequencer.sv
// Directed testbench for key_schedule_sequencer using FIPS-197 key-expansion vectors
// for 128-, 192- and 256-bit keys. Early-read expectations follow KEYSCHED_EARLY_READ_EN.
module tb_key_schedule_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    key_schedule_sequencer_if #(.KEY_SIZE(128)) bus128();
    key_schedule_sequencer_if #(.KEY_SIZE(192)) bus192();
    key_schedule_sequencer_if #(.KEY_SIZE(256)) bus256();

    key_schedule_sequencer #(.KEY_SIZE(128), .NUM_ROUNDS(10)) u_dut128 (
        .clock(clk), .reset(rst), .bus(bus128));
    key_schedule_sequencer #(.KEY_SIZE(192), .NUM_ROUNDS(12)) u_dut192 (
        .clock(clk), .reset(rst), .bus(bus192));
    key_schedule_sequencer #(.KEY_SIZE(256), .NUM_ROUNDS(14)) u_dut256 (
        .clock(clk), .reset(rst), .bus(bus256));

    localparam logic [127:0] KEY128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1_128   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10_128  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEYC1    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R10_C1   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [191:0] KEY192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        total++; if (bus128.keyReady !== 1'b1) begin bad++; $display("FAIL reset_keyReady got=%b exp=1", bus128.keyReady); end
        total++; if (bus128.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus128.busy); end
        total++; if (bus128.scheduleValid !== 1'b0) begin bad++; $display("FAIL reset_scheduleValid got=%b exp=0", bus128.scheduleValid); end
        total++; if (bus128.rdKey !== 128'h0) begin bad++; $display("FAIL reset_rdKey got=%h exp=0", bus128.rdKey); end
        total++; if (bus128.rdValid !== 1'b0) begin bad++; $display("FAIL reset_rdValid got=%b exp=0", bus128.rdValid); end
        total++; if (bus256.keyReady !== 1'b1) begin bad++; $display("FAIL reset_keyReady256 got=%b exp=1", bus256.keyReady); end
        bus128.rdIndex = 4'd0;
        tick;
        total++; if (bus128.rdKey !== 128'h0) begin bad++; $display("FAIL reset_store0 got=%h exp=0", bus128.rdKey); end
    endtask

    task automatic test_expand128;
        int cnt;
        int rv_cnt;
        bit busy_gap;
        bus128.rdIndex  = 4'd1;
        bus128.keyIn    = KEY128;
        bus128.keyValid = 1'b1;
        tick;  // E0
        bus128.keyValid = 1'b0;
        total++; if (bus128.busy !== 1'b1 || bus128.keyReady !== 1'b0) begin bad++; $display("FAIL e0_flags got busy=%b ready=%b exp busy=1 ready=0", bus128.busy, bus128.keyReady); end
        cnt = 0; rv_cnt = -1; busy_gap = 1'b0;
        while (bus128.scheduleValid !== 1'b1 && cnt < 200) begin
            tick;
            cnt++;
            if (bus128.scheduleValid !== 1'b1 && bus128.busy !== 1'b1) busy_gap = 1'b1;
            if (bus128.scheduleValid !== 1'b1 && bus128.rdValid === 1'b1 && rv_cnt < 0) rv_cnt = cnt;
        end
        total++; if (cnt != 40) begin bad++; $display("FAIL lat128 got=%0d exp=40", cnt); end
        total++; if (busy_gap) begin bad++; $display("FAIL busy128_gap got=1 exp=0"); end
        total++; if (bus128.busy !== 1'b0 || bus128.keyReady !== 1'b1) begin bad++; $display("FAIL done128_flags got busy=%b ready=%b exp busy=0 ready=1", bus128.busy, bus128.keyReady); end
`ifdef KEYSCHED_EARLY_READ_EN
        total++; if (rv_cnt != 4) begin bad++; $display("FAIL early_rdValid got=%0d exp=4", rv_cnt); end
`else
        total++; if (rv_cnt != -1) begin bad++; $display("FAIL early_rdValid got=%0d exp=-1", rv_cnt); end
`endif
        bus128.rdIndex = 4'd10;
        tick;
        total++; if (bus128.rdKey !== R10_128) begin bad++; $display("FAIL r10_128 got=%h exp=%h", bus128.rdKey, R10_128); end
        total++; if (bus128.rdValid !== 1'b1) begin bad++; $display("FAIL r10_valid got=%b exp=1", bus128.rdValid); end
        bus128.rdIndex = 4'd0;
        tick;
        total++; if (bus128.rdKey !== KEY128) begin bad++; $display("FAIL r0_128 got=%h exp=%h", bus128.rdKey, KEY128); end
        bus128.rdIndex = 4'd1;
        tick;
        total++; if (bus128.rdKey !== R1_128) begin bad++; $display("FAIL r1_128 got=%h exp=%h", bus128.rdKey, R1_128); end
    endtask

    task automatic test_out_of_range;
        bus128.rdIndex = 4'd15;
        tick;
        total++; if (bus128.rdKey !== 128'h0 || bus128.rdValid !== 1'b0) begin bad++; $display("FAIL oor15 got key=%h v=%b exp key=0 v=0", bus128.rdKey, bus128.rdValid); end
        bus128.rdIndex = 4'd11;
        tick;
        total++; if (bus128.rdKey !== 128'h0 || bus128.rdValid !== 1'b0) begin bad++; $display("FAIL oor11 got key=%h v=%b exp key=0 v=0", bus128.rdKey, bus128.rdValid); end
    endtask

    task automatic test_reset_mid;
        bus128.keyIn    = KEY128;
        bus128.keyValid = 1'b1;
        tick;  // E0
        bus128.keyValid = 1'b0;
        repeat (20) tick;
        rst = 1'b1;
        tick;
        total++; if (bus128.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus128.busy); end
        total++; if (bus128.keyReady !== 1'b1) begin bad++; $display("FAIL mid_keyReady got=%b exp=1", bus128.keyReady); end
        total++; if (bus128.scheduleValid !== 1'b0) begin bad++; $display("FAIL mid_scheduleValid got=%b exp=0", bus128.scheduleValid); end
        rst = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            bus128.rdIndex = 4'(r);
            tick;
            total++; if (bus128.rdKey !== 128'h0) begin bad++; $display("FAIL mid_clear idx=%0d got=%h exp=0", r, bus128.rdKey); end
        end
    endtask

    task automatic test_rekey;
        int cnt;
        // First bring up a complete schedule for a different key.
        bus128.keyIn    = KEY128;
        bus128.keyValid = 1'b1;
        tick;
        bus128.keyValid = 1'b0;
        cnt = 0;
        while (bus128.scheduleValid !== 1'b1 && cnt < 200) begin tick; cnt++; end
        total++; if (bus128.scheduleValid !== 1'b1) begin bad++; $display("FAIL rekey_first_done got=%b exp=1", bus128.scheduleValid); end
        // Rekey from DONE with keyValid held.
        bus128.keyIn    = KEYC1;
        bus128.keyValid = 1'b1;
        tick;  // E0
        total++; if (bus128.scheduleValid !== 1'b0 || bus128.busy !== 1'b1) begin bad++; $display("FAIL rekey_drop got sv=%b busy=%b exp sv=0 busy=1", bus128.scheduleValid, bus128.busy); end
        cnt = 0;
        for (int j = 0; j < 10; j++) begin
            bus128.keyValid = (j % 2 == 0);
            bus128.keyIn    = ~KEYC1;
            tick;
            cnt++;
        end
        bus128.keyValid = 1'b0;
        while (bus128.scheduleValid !== 1'b1 && cnt < 200) begin tick; cnt++; end
        total++; if (cnt != 40) begin bad++; $display("FAIL rekey_lat got=%0d exp=40", cnt); end
        bus128.rdIndex = 4'd10;
        tick;
        total++; if (bus128.rdKey !== R10_C1) begin bad++; $display("FAIL rekey_r10 got=%h exp=%h", bus128.rdKey, R10_C1); end
        bus128.rdIndex = 4'd0;
        tick;
        total++; if (bus128.rdKey !== KEYC1) begin bad++; $display("FAIL rekey_r0 got=%h exp=%h", bus128.rdKey, KEYC1); end
    endtask

    task automatic test_expand192;
        int cnt;
        bus192.rdIndex  = 4'd0;
        bus192.keyIn    = KEY192;
        bus192.keyValid = 1'b1;
        tick;
        bus192.keyValid = 1'b0;
        cnt = 0;
        while (bus192.scheduleValid !== 1'b1 && cnt < 200) begin tick; cnt++; end
        total++; if (cnt != 46) begin bad++; $display("FAIL lat192 got=%0d exp=46", cnt); end
        bus192.rdIndex = 4'd12;
        tick;
        total++; if (bus192.rdKey[31:0] !== 32'h01002202) begin bad++; $display("FAIL w51 got=%h exp=01002202", bus192.rdKey[31:0]); end
        bus192.rdIndex = 4'd1;
        tick;
        total++; if (bus192.rdKey[127:64] !== KEY192[63:0]) begin bad++; $display("FAIL r1_192_hi got=%h exp=%h", bus192.rdKey[127:64], KEY192[63:0]); end
    endtask

    task automatic test_expand256;
        int cnt;
        bus256.rdIndex  = 4'd0;
        bus256.keyIn    = KEY256;
        bus256.keyValid = 1'b1;
        tick;
        bus256.keyValid = 1'b0;
        cnt = 0;
        while (bus256.scheduleValid !== 1'b1 && cnt < 200) begin tick; cnt++; end
        total++; if (cnt != 52) begin bad++; $display("FAIL lat256 got=%0d exp=52", cnt); end
        bus256.rdIndex = 4'd14;
        tick;
        total++; if (bus256.rdKey[31:0] !== 32'h706c631e) begin bad++; $display("FAIL w59 got=%h exp=706c631e", bus256.rdKey[31:0]); end
        bus256.rdIndex = 4'd1;
        tick;
        total++; if (bus256.rdKey !== KEY256[127:0]) begin bad++; $display("FAIL r1_256 got=%h exp=%h", bus256.rdKey, KEY256[127:0]); end
        bus256.rdIndex = 4'd15;
        tick;
        total++; if (bus256.rdKey !== 128'h0 || bus256.rdValid !== 1'b0) begin bad++; $display("FAIL oor256 got key=%h v=%b exp key=0 v=0", bus256.rdKey, bus256.rdValid); end
    endtask

    initial begin
        bus128.keyValid = 1'b0; bus128.keyIn = '0; bus128.rdIndex = 4'd0;
        bus192.keyValid = 1'b0; bus192.keyIn = '0; bus192.rdIndex = 4'd0;
        bus256.keyValid = 1'b0; bus256.keyIn = '0; bus256.rdIndex = 4'd0;
        @(negedge clk);
        test_reset;
        test_expand128;
        test_out_of_range;
        test_reset_mid;
        test_rekey;
        test_expand192;
        test_expand256;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
